// File: rtl/input_port_buffer.sv
// Per-input-port wormhole flit FIFO for a mesh router: routes the head flit, then
// streams the packet to the switch allocator. Optional macro: INPUT_BUFFER_OCCUPANCY_EN.
package input_port_buffer_pkg;
  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } inout_Port;
endpackage

module input_port_buffer
  import input_port_buffer_pkg::*;
#(
  parameter int FLIT_SIZE       = 32,
  parameter int BUFFER_SIZE     = 8,
  parameter int x_Des_Addr_Size = 4,
  parameter int y_Des_Addr_Size = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_In,
  input  logic [FLIT_SIZE-1:0]       flit_In,
  output logic                       ready_Out,
  output logic [x_Des_Addr_Size-1:0] x_Dest,
  output logic [y_Des_Addr_Size-1:0] y_Dest,
  input  inout_Port                  port_In,
  output logic                       sa_Request,
  output inout_Port                  sa_Port,
  input  logic                       sa_Grant,
  output logic [FLIT_SIZE-1:0]       flit_Out,
  output logic                       valid_Out,
  output logic                       drop_Out
`ifdef INPUT_BUFFER_OCCUPANCY_EN
  ,
  output logic [$clog2(BUFFER_SIZE):0] occupancy
`endif
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} state_t;

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  state_t               state;
  inout_Port            route_q;

  logic                 empty, full, push, pop;
  logic                 drop_pop, grant_pop;
  logic [FLIT_SIZE-1:0] head;
  logic [1:0]           head_type;
  logic                 head_is_start, head_is_end;

  assign empty     = (count == '0);
  assign full      = (count == CW'(BUFFER_SIZE));
  assign head      = mem[rd_ptr];
  assign head_type = head[FLIT_SIZE-1 -: 2];
  // HEAD=00 and HEADTAIL=11 open a packet; TAIL=10 and HEADTAIL=11 close one.
  assign head_is_start = (head_type[1] == head_type[0]);
  assign head_is_end   = head_type[1];

  assign ready_Out = !rst && !full;
  assign push      = valid_In && ready_Out;

  assign drop_pop   = (state == IDLE) && !empty && !head_is_start;
  assign sa_Request = (state == ACTIVE) && !empty;
  assign grant_pop  = sa_Request && sa_Grant;
  assign pop        = drop_pop || grant_pop;

  assign valid_Out = grant_pop;
  assign drop_Out  = drop_pop;
  assign sa_Port   = route_q;
  // Stale slot contents are masked so an empty buffer presents all-zero outputs.
  assign flit_Out  = empty ? '0 : head;
  assign x_Dest    = empty ? '0 : head[x_Des_Addr_Size-1:0];
  assign y_Dest    = empty ? '0 : head[x_Des_Addr_Size+y_Des_Addr_Size-1:x_Des_Addr_Size];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_In;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      route_q <= LOCAL;
    end else begin
      case (state)
        IDLE:   if (!empty && head_is_start) state <= ROUTE;
        ROUTE: begin
          route_q <= port_In;
          state   <= ACTIVE;
        end
        // An empty buffer mid-packet just holds here with the route kept.
        ACTIVE: if (grant_pop && head_is_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INPUT_BUFFER_OCCUPANCY_EN
  assign occupancy = count;
`endif

endmodule
